seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Display-side counterpart of the engine key-check FSM. It accepts the two 3-bit symbol codes the FSM emits (blank, U, P, C, H, F, A) and decodes them to active-low 7-segment patterns. It time-multiplexes the two digits onto one shared segment bus, with dead-time between digits and optional blinking for the error display. It sits between the lock FSM outputs and the board's 2-digit common-anode display.

## Interface
- SCAN_DIV, 1000: clock cycles per digit slot; legal range SCAN_DIV ≥ DEAD+2.
- DEAD, 2: blanking cycles at the start of each slot; legal range DEAD ≥ 1.
- BLINK_DIV, 256: frames per blink half-period; legal range BLINK_DIV ≥ 1.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- sym1  in  3  symbol code for the left digit.
- sym0  in  3  symbol code for the right digit.
- load  in  1  1-cycle strobe; capture sym1/sym0.
- blink_en  in  1  level; enables blinking of both digits.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dig  out  2  digit enables, active-low; dig[0] is the right digit, dig[1] is the left digit.
- frame_tick  out  1  1-cycle pulse on the first cycle of each frame.

## Operation
- Symbol codes and seg values:
  - 0 blank → 7'h7F
  - 1 U → 7'h41
  - 2 P → 7'h0C
  - 3 C → 7'h46
  - 4 H → 7'h09
  - 5 F → 7'h0E
  - 6 A → 7'h08
  - 7 dash → 7'h3F
- Two register banks:
  - pending: written on load.
  - active: drives the display.
- Bank transfer: pending is copied to active on the last cycle of every slot (slot wrap).
  - load coincident with wrap: the new sym values go straight to active and pending.
  - Multiple loads within one slot: the last one wins.
- Scan FSM states: DEAD0 → SHOW0 → DEAD1 → SHOW1 → DEAD0.
  - DEADx lasts DEAD cycles; SHOWx lasts SCAN_DIV−DEAD cycles.
  - Slot counter counts 0..SCAN_DIV−1 and wraps at SHOWx exit.
- Outputs per state:
  - DEADx: dig=2'b11, seg=7'h7F.
  - SHOW0: dig=2'b10, seg=pattern(active sym0).
  - SHOW1: dig=2'b01, seg=pattern(active sym1).
- Blink:
  - phase register, reset value 1 (on).
  - Frame counter counts completed frames; at BLINK_DIV frames, phase toggles and the counter clears.
  - blink_en=1 and phase=0: SHOWx behaves as DEADx (dig=11, seg=7F).
  - blink_en=0: display always on; phase and frame counter keep running.
- Counter widths: $clog2 of the respective divider; no other arithmetic.
- Reset (any time, including mid-slot):
  - seg=7'h7F, dig=2'b11, frame_tick=0.
  - FSM=DEAD0, all counters 0, pending=active=0 (blank), phase=1.

## Timing
- All outputs are registered and change one cycle after the state/counter edge that selects them.
- Both digits are never enabled in the same cycle; at least DEAD cycles of dig=11 separate the two enables.
- frame_tick asserts on the first DEAD0 cycle of each frame.
  - First assertion is the first clock after reset deasserts.
  - Period thereafter: 2·SCAN_DIV cycles.
- Load latency: a new symbol becomes visible at the next SHOW of its digit after the following slot wrap.
  - Worst case ≈ 2·SCAN_DIV + 1 cycles.
- Frame length 2·SCAN_DIV; blink half-period 2·SCAN_DIV·BLINK_DIV cycles.

## Structure
- Shared package (shared with the lock FSM) holds:
  - symbol code constants SYM_BLANK..SYM_DASH (3-bit);
  - segment pattern constants;
  - scan state encoding.
- Sub-module sym_to_seg: a purely combinational 3→7 decoder, instantiated once on the muxed active symbol.
- Top level holds the FSM, counters, register banks and output registers.

## Test plan
All scenarios use SCAN_DIV=8, DEAD=2, BLINK_DIV=2.
- Reset release:
  - Stimulus: hold reset 3 cycles, release.
  - Response: seg=7F and dig=11 during reset; frame_tick every 16 cycles; dig pattern 11,11,10×6,11,11,01×6 repeating; seg=7F throughout.
- Static U/P:
  - Stimulus: load with sym1=1, sym0=2.
  - Response: from the following frame, SHOW0 gives seg=0C/dig=10 and SHOW1 gives seg=41/dig=01.
- Mid-slot load:
  - Stimulus: load C/H at slot cycle 4, then F/A at cycle 6.
  - Response: the next SHOW shows F/A (0E/08); C/H never appears.
- Load at wrap:
  - Stimulus: load coincident with the slot-wrap cycle.
  - Response: the next slot already shows the new symbol.
- Blink:
  - Stimulus: sym0=6, blink_en=1.
  - Response: 08 visible for 2 frames (32 cycles), then dig=11/seg=7F for 32 cycles, repeating; sym=7 shows 3F.
- Reset mid-SHOW1:
  - Stimulus: assert reset asynchronously during SHOW1.
  - Response: dig=11 and seg=7F immediately, without waiting for a clock; after release, active=blank until the next load.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the key-check display path: symbol codes, segment
// patterns (active-low {g,f,e,d,c,b,a}), digit enables and scan state encoding.
package seg_scan_driver_pkg;

  localparam logic [2:0] SYM_BLANK = 3'd0;
  localparam logic [2:0] SYM_U     = 3'd1;
  localparam logic [2:0] SYM_P     = 3'd2;
  localparam logic [2:0] SYM_C     = 3'd3;
  localparam logic [2:0] SYM_H     = 3'd4;
  localparam logic [2:0] SYM_F     = 3'd5;
  localparam logic [2:0] SYM_A     = 3'd6;
  localparam logic [2:0] SYM_DASH  = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low digit enables: bit 0 is the right digit, bit 1 the left digit.
  localparam logic [1:0] DIG_OFF   = 2'b11;
  localparam logic [1:0] DIG_RIGHT = 2'b10;
  localparam logic [1:0] DIG_LEFT  = 2'b01;

  typedef enum logic [1:0] {
    ST_DEAD0 = 2'd0,
    ST_SHOW0 = 2'd1,
    ST_DEAD1 = 2'd2,
    ST_SHOW1 = 2'd3
  } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_sym_to_seg.sv
// Combinational symbol-code to active-low 7-segment pattern decoder.
module seg_scan_driver_sym_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [2:0] i_sym,
  output logic [6:0] o_seg
);

  // Map each 3-bit symbol code onto its segment pattern.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_sym)
      SYM_BLANK: o_seg = SEG_BLANK;
      SYM_U:     o_seg = SEG_U;
      SYM_P:     o_seg = SEG_P;
      SYM_C:     o_seg = SEG_C;
      SYM_H:     o_seg = SEG_H;
      SYM_F:     o_seg = SEG_F;
      SYM_A:     o_seg = SEG_A;
      SYM_DASH:  o_seg = SEG_DASH;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver with per-slot dead time, double
// buffered symbol banks and optional frame-based blinking.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEAD      = 2,
  parameter int BLINK_DIV = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_sym1,
  input  logic [2:0] i_sym0,
  input  logic       i_load,
  input  logic       i_blink_en,
  output logic [6:0] o_seg,
  output logic [1:0] o_dig,
  output logic       o_frame_tick
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD_LAST  = SW'(DEAD - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  scan_state_e   r_state;
  logic [SW-1:0] r_slot;
  logic [FW-1:0] r_frames;
  logic          r_phase;
  logic [2:0]    r_pend1;
  logic [2:0]    r_pend0;
  logic [2:0]    r_act1;
  logic [2:0]    r_act0;

  logic          w_in_show;
  logic          w_wrap;
  logic          w_frame_end;
  logic          w_show;
  logic [2:0]    w_sym;
  logic [6:0]    w_pat;

  // The slot counter only reaches its last value inside a SHOW state, so that
  // value alone marks the slot wrap; the wrap out of SHOW1 also ends a frame.
  assign w_in_show   = (r_state == ST_SHOW0) || (r_state == ST_SHOW1);
  assign w_wrap      = w_in_show && (r_slot == SLOT_LAST);
  assign w_frame_end = (r_state == ST_SHOW1) && (r_slot == SLOT_LAST);
  assign w_show      = w_in_show && (!i_blink_en || r_phase);
  assign w_sym       = (r_state == ST_SHOW1) ? r_act1 : r_act0;

  seg_scan_driver_sym_to_seg u_sym_to_seg (
    .i_sym (w_sym),
    .o_seg (w_pat)
  );

  // Scan FSM with slot counter; outputs are registered from the current state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_DEAD0;
      r_slot       <= '0;
      o_seg        <= SEG_BLANK;
      o_dig        <= DIG_OFF;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= (r_state == ST_DEAD0) && (r_slot == '0);
      o_seg        <= w_show ? w_pat : SEG_BLANK;
      if (!w_show) begin
        o_dig <= DIG_OFF;
      end else if (r_state == ST_SHOW0) begin
        o_dig <= DIG_RIGHT;
      end else begin
        o_dig <= DIG_LEFT;
      end

      r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);

      case (r_state)
        ST_DEAD0: if (r_slot == DEAD_LAST) r_state <= ST_SHOW0;
        ST_SHOW0: if (r_slot == SLOT_LAST) r_state <= ST_DEAD1;
        ST_DEAD1: if (r_slot == DEAD_LAST) r_state <= ST_SHOW1;
        ST_SHOW1: if (r_slot == SLOT_LAST) r_state <= ST_DEAD0;
        default:  r_state <= ST_DEAD0;
      endcase
    end
  end

  // Count completed frames and flip the blink phase every BLINK_DIV frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frames <= '0;
      r_phase  <= 1'b1;
    end else if (w_frame_end) begin
      if (r_frames == FRAME_LAST) begin
        r_frames <= '0;
        r_phase  <= ~r_phase;
      end else begin
        r_frames <= r_frames + FW'(1);
      end
    end
  end

  // Pending bank takes every load; active bank refreshes only at slot wrap so a
  // digit never changes mid-slot. A load on the wrap cycle bypasses pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend1 <= SYM_BLANK;
      r_pend0 <= SYM_BLANK;
      r_act1  <= SYM_BLANK;
      r_act0  <= SYM_BLANK;
    end else begin
      if (i_load) begin
        r_pend1 <= i_sym1;
        r_pend0 <= i_sym0;
      end
      if (w_wrap) begin
        r_act1 <= i_load ? i_sym1 : r_pend1;
        r_act0 <= i_load ? i_sym0 : r_pend0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a time-based reference model pushes the
// expected display state each clock, and a monitor compares it 1 time unit later.
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int DEAD      = 2;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 2 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       blink_en = 1'b0;
  logic [2:0] sym1 = 3'd0;
  logic [2:0] sym0 = 3'd0;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       tick;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .DEAD      (DEAD),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sym1       (sym1),
    .i_sym0       (sym0),
    .i_load       (load),
    .i_blink_en   (blink_en),
    .o_seg        (seg),
    .o_dig        (dig),
    .o_frame_tick (tick)
  );

  typedef struct packed {
    logic [6:0]  seg;
    logic [1:0]  dig;
    logic        tick;
    logic [31:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Segment table straight from the symbol list.
  function automatic logic [6:0] pat(input logic [2:0] s);
    case (s)
      3'd0: return 7'h7F;
      3'd1: return 7'h41;
      3'd2: return 7'h0C;
      3'd3: return 7'h46;
      3'd4: return 7'h09;
      3'd5: return 7'h0E;
      3'd6: return 7'h08;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference model: n counts clocks since reset release; the display position
  // of the DUT state seen at clock n is n-1 inside the repeating 16-cycle frame.
  int unsigned n_clk = 0;
  logic [2:0]  m_pend1 = 3'd0, m_pend0 = 3'd0, m_act1 = 3'd0, m_act0 = 3'd0;
  exp_t        mx;
  int          p, off, slot, frm;
  bit          vis;

  always @(posedge clk) begin
    if (rst) begin
      n_clk = 0;
      m_pend1 = 3'd0; m_pend0 = 3'd0; m_act1 = 3'd0; m_act0 = 3'd0;
      mx = '{seg: 7'h7F, dig: 2'b11, tick: 1'b0, idx: 32'd0};
    end else begin
      n_clk++;
      p    = int'((n_clk - 1) % FRAME);
      frm  = int'((n_clk - 1) / FRAME);
      slot = p / SCAN_DIV;
      off  = p % SCAN_DIV;
      vis  = (off >= DEAD) && (!blink_en || (((frm / BLINK_DIV) % 2) == 0));
      mx.idx  = n_clk;
      mx.tick = (p == 0);
      mx.dig  = !vis ? 2'b11 : ((slot == 0) ? 2'b10 : 2'b01);
      mx.seg  = !vis ? 7'h7F : pat((slot == 0) ? m_act0 : m_act1);
      if (load) begin
        m_pend1 = sym1;
        m_pend0 = sym0;
      end
      if (off == SCAN_DIV - 1) begin
        m_act1 = m_pend1;
        m_act0 = m_pend0;
      end
    end
    exp_q.push_back(mx);
  end

  // Monitor: pop one expectation per clock and compare just after the edge.
  exp_t ex;
  always @(posedge clk) begin
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at t=%0t", $time);
    end else begin
      ex = exp_q.pop_front();
      if ({seg, dig, tick} !== {ex.seg, ex.dig, ex.tick}) begin
        failures++;
        $display("FAIL cycle%0d got seg=%h dig=%b tick=%b want seg=%h dig=%b tick=%b",
                 ex.idx, seg, dig, tick, ex.seg, ex.dig, ex.tick);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Wait (at a negedge) until the next sampled position satisfies pos%m == k.
  task automatic wait_pos(input int m, input int k);
    int guard;
    guard = 0;
    while ((int'(n_clk % m) != k) && (guard < 64)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      failures++;
      $display("FAIL wait_pos timeout m=%0d k=%0d", m, k);
    end
  endtask

  task automatic do_load(input logic [2:0] s1, input logic [2:0] s0);
    sym1 = s1;
    sym0 = s0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic direct_check(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    // Reset release, then blank display.
    cycles(3);
    rst = 1'b0;
    cycles(40);

    // Static U/P.
    do_load(3'd1, 3'd2);
    cycles(40);

    // Mid-slot loads: C/H at offset 4, F/A at offset 6; last one wins.
    wait_pos(SCAN_DIV, 4);
    do_load(3'd3, 3'd4);
    wait_pos(SCAN_DIV, 6);
    do_load(3'd5, 3'd6);
    cycles(24);

    // Load coincident with slot wrap.
    wait_pos(SCAN_DIV, SCAN_DIV - 1);
    do_load(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    cycles(24);

    // Blink with A on the right and dash on the left.
    do_load(3'd7, 3'd6);
    blink_en = 1'b1;
    cycles(96);
    blink_en = 1'b0;

    // Randomized loads and blink toggling.
    for (int i = 0; i < 400; i++) begin
      sym1 = 3'($urandom_range(0, 7));
      sym0 = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 47) == 0) blink_en = ~blink_en;
      @(negedge clk);
    end
    load = 1'b0;
    blink_en = 1'b0;

    // Asynchronous reset in the middle of SHOW1.
    do_load(3'd1, 3'd2);
    cycles(2 * FRAME);
    wait_pos(FRAME, 12);
    direct_check("pre_reset_show1", {seg, dig, 1'b0}, {7'h41, 2'b01, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    direct_check("async_reset_out", {seg, dig, tick}, {7'h7F, 2'b11, 1'b0});
    cycles(2);
    rst = 1'b0;
    cycles(40);

    // Display resumes after a fresh load.
    do_load(3'd4, 3'd5);
    cycles(40);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
